// File: rtl/gate_sequencer.sv
// gate_sequencer
// Measurement-cycle controller for the frequency-meter counter/latch datapath.
// It repeats clear -> count for a gate window -> latch -> display hold. The gate
// length comes from testMode (manual) or from an automatic search that starts at
// the longest gate and steps down one range each time the counter overflows.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   testMode    manual range select (ignored for range choice when autoRange=1)
//   autoRange   1 = automatic range search, 0 = manual
//   ovf         counter carry-out, only looked at during GATE
//   enable      counter count enable, active-high
//   clear       counter clear, active-low
//   latch       result latch: 0 = transparent/load, 1 = hold
//   range       gate range of the current/last measurement
//   meas_done   one-cycle pulse, coincident with latch=0
//   over_range  last latched result overflowed
//
// state   | meaning
// --------+------------------------------------------------------------
// S_CLEAR | counter held in clear for one cycle, gate timer loaded
// S_GATE  | counter enabled, timer counts G[range] cycles down to zero
// S_LATCH | result loaded into the latch bank, meas_done pulses
// S_HOLD  | result displayed for HOLD cycles before the next measurement
module gate_sequencer #(
    parameter int CNT_W = 24,
    parameter int GATE0 = 1000,
    parameter int GATE1 = 10000,
    parameter int GATE2 = 100000,
    parameter int GATE3 = 1000000,
    parameter int HOLD  = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] testMode,
    input  logic       autoRange,
    input  logic       ovf,
    output logic       enable,
    output logic       clear,
    output logic       latch,
    output logic [1:0] range,
    output logic       meas_done,
    output logic       over_range
);

    typedef enum logic [1:0] {S_CLEAR, S_GATE, S_LATCH, S_HOLD} state_t;

    // Timer terminal values: a window of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] G0_LAST   = CNT_W'(GATE0 - 1);
    localparam logic [CNT_W-1:0] G1_LAST   = CNT_W'(GATE1 - 1);
    localparam logic [CNT_W-1:0] G2_LAST   = CNT_W'(GATE2 - 1);
    localparam logic [CNT_W-1:0] G3_LAST   = CNT_W'(GATE3 - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [1:0]       testModeQ;
    logic             autoRangeQ;
    logic             modeChange;
    logic [1:0]       restartRange;

    // A testMode change only matters while manual mode is in force on both
    // sides of the comparison; any autoRange toggle is always a change.
    assign modeChange   = (autoRange != autoRangeQ) ||
                          (!autoRange && (testMode != testModeQ));
    assign restartRange = autoRange ? 2'd3 : testMode;

    function automatic logic [CNT_W-1:0] gateLast(input logic [1:0] r);
        case (r)
            2'd0:    gateLast = G0_LAST;
            2'd1:    gateLast = G1_LAST;
            2'd2:    gateLast = G2_LAST;
            default: gateLast = G3_LAST;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CLEAR;
            timer      <= '0;
            range      <= restartRange;
            enable     <= 1'b0;
            clear      <= 1'b0;
            latch      <= 1'b1;
            meas_done  <= 1'b0;
            over_range <= 1'b0;
            testModeQ  <= testMode;
            autoRangeQ <= autoRange;
        end else begin
            testModeQ <= testMode;
            autoRangeQ <= autoRange;
            meas_done <= 1'b0;
            if (modeChange) begin
                // Mode change wins over timer expiry and ovf.
                state  <= S_CLEAR;
                range  <= restartRange;
                enable <= 1'b0;
                clear  <= 1'b0;
                latch  <= 1'b1;
            end else begin
                case (state)
                    S_CLEAR: begin
                        timer  <= gateLast(range);
                        state  <= S_GATE;
                        enable <= 1'b1;
                        clear  <= 1'b1;
                        latch  <= 1'b1;
                    end
                    S_GATE: begin
                        if (ovf && autoRange && (range != 2'd0)) begin
                            // Auto search: drop a range and retry, nothing latched.
                            state  <= S_CLEAR;
                            range  <= range - 2'd1;
                            enable <= 1'b0;
                            clear  <= 1'b0;
                            latch  <= 1'b1;
                        end else if (ovf || (timer == '0)) begin
                            state      <= S_LATCH;
                            enable     <= 1'b0;
                            clear      <= 1'b1;
                            latch      <= 1'b0;
                            meas_done  <= 1'b1;
                            over_range <= ovf;
                        end else begin
                            timer <= timer - CNT_W'(1);
                        end
                    end
                    S_LATCH: begin
                        timer  <= HOLD_LAST;
                        state  <= S_HOLD;
                        enable <= 1'b0;
                        clear  <= 1'b1;
                        latch  <= 1'b1;
                    end
                    default: begin
                        if (timer == '0) begin
                            state  <= S_CLEAR;
                            range  <= restartRange;
                            enable <= 1'b0;
                            clear  <= 1'b0;
                            latch  <= 1'b1;
                        end else begin
                            timer <= timer - CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule
